// File: rtl/atomic_seq_pkg.sv
// atomic_seq_pkg: shared reservation, atomic op/status and sequencer state encodings
package atomic_seq_pkg;
    localparam int ReserveOp_WIDTH = 2;
    localparam logic [ReserveOp_WIDTH-1:0] ReserveOp_NONE = 2'd0;
    localparam logic [ReserveOp_WIDTH-1:0] ReserveOp_LD   = 2'd1;
    localparam logic [ReserveOp_WIDTH-1:0] ReserveOp_ST   = 2'd2;
    localparam int AtomOp_WIDTH = 2;
    localparam logic [AtomOp_WIDTH-1:0] AtomOp_SWAP = 2'b00;
    localparam logic [AtomOp_WIDTH-1:0] AtomOp_ADD  = 2'b01;
    localparam logic [AtomOp_WIDTH-1:0] AtomOp_AND  = 2'b10;
    localparam logic [AtomOp_WIDTH-1:0] AtomOp_CAS  = 2'b11;
    localparam int AtomSt_WIDTH = 2;
    localparam logic [AtomSt_WIDTH-1:0] AtomSt_OK       = 2'b00;
    localparam logic [AtomSt_WIDTH-1:0] AtomSt_CMP_FAIL = 2'b01;
    localparam logic [AtomSt_WIDTH-1:0] AtomSt_RETRY    = 2'b10;
    localparam logic [AtomSt_WIDTH-1:0] AtomSt_MISALIGN = 2'b11;
    typedef enum logic [2:0] {
        ATOM_IDLE,
        ATOM_LOAD,
        ATOM_CALC,
        ATOM_STORE,
        ATOM_RESP
    } atom_state_e;
endpackage

// File: rtl/atomic_seq_if.sv
// atomic_seq_if: request/response handshake between a bus master and the atomic sequencer
interface atomic_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_operand;
    logic [DATA_W-1:0] req_cmp;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;
    modport master (
        output req_valid, req_op, req_addr, req_operand, req_cmp, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_status
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_operand, req_cmp, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/atomic_alu.sv
// atomic_alu: combinational new-value and CAS compare for one atomic op
module atomic_alu
    import atomic_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [AtomOp_WIDTH-1:0] op,
    input  logic [DATA_W-1:0]       old,
    input  logic [DATA_W-1:0]       operand,
    input  logic [DATA_W-1:0]       cmp,
    output logic [DATA_W-1:0]       new_val,
    output logic                    cmp_ok
);
    assign new_val = op == AtomOp_ADD ? old + operand :
                     op == AtomOp_AND ? old & operand : operand;
    assign cmp_ok  = op != AtomOp_CAS || old == cmp;
endmodule

// File: rtl/atomic_seq.sv
// atomic_seq: load-reserve / store-conditional read-modify-write sequencer with bounded retry
module atomic_seq
    import atomic_seq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    atomic_seq_if.slave                bus,
    output logic                       dm_rd_en,
    output logic [ADDR_W-1:0]          dm_addr,
    input  logic [DATA_W-1:0]          dm_rdata,
    output logic                       dm_wr_en,
    output logic [DATA_W-1:0]          dm_wdata,
    output logic [ReserveOp_WIDTH-1:0] rsv_op,
    output logic [ADDR_W-1:0]          rsv_addr,
    output logic [3:0]                 rsv_length,
    input  logic                       cr0_eq
);
    localparam logic [3:0] MAX_R = 4'(MAX_RETRY);
    atom_state_e state, state_nxt;
    logic [AtomOp_WIDTH-1:0] op_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       operand_q, cmp_q, wdata_q, rsp_data_q;
    logic [AtomSt_WIDTH-1:0] status_q;
    logic [3:0]              retry_q;
    logic [DATA_W-1:0]       alu_new;
    logic                    alu_cmp_ok, accept, misaligned, retry_left;

    atomic_alu #(.DATA_W(DATA_W)) u_alu (
        .op(op_q), .old(dm_rdata), .operand(operand_q), .cmp(cmp_q),
        .new_val(alu_new), .cmp_ok(alu_cmp_ok)
    );

    assign accept     = state == ATOM_IDLE && bus.req_valid;
    assign misaligned = bus.req_addr[1:0] != 2'b00;
    assign retry_left = retry_q < MAX_R;

    always_comb begin
        state_nxt = state;
        case (state)
            ATOM_IDLE:  state_nxt = bus.req_valid ? (misaligned ? ATOM_RESP : ATOM_LOAD) : ATOM_IDLE;
            ATOM_LOAD:  state_nxt = ATOM_CALC;
            ATOM_CALC:  state_nxt = alu_cmp_ok ? ATOM_STORE : ATOM_RESP;
            ATOM_STORE: state_nxt = (cr0_eq || !retry_left) ? ATOM_RESP : ATOM_LOAD;
            ATOM_RESP:  state_nxt = bus.rsp_ready ? ATOM_IDLE : ATOM_RESP;
            default:    state_nxt = ATOM_IDLE;
        endcase
    end

    assign bus.req_ready  = state == ATOM_IDLE;
    assign bus.rsp_valid  = state == ATOM_RESP;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = status_q;
    assign dm_rd_en       = state == ATOM_LOAD;
    assign dm_wr_en       = state == ATOM_STORE;
    assign dm_wdata       = wdata_q;
    assign dm_addr        = addr_q;
    assign rsv_addr       = addr_q;
    assign rsv_length     = 4'd4;
    assign rsv_op         = state == ATOM_LOAD ? ReserveOp_LD :
                            state == ATOM_STORE ? ReserveOp_ST : ReserveOp_NONE;

    // Status is staged ahead of RESP; it is only observed once rsp_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ATOM_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            operand_q  <= '0;
            cmp_q      <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            status_q   <= AtomSt_OK;
            retry_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= bus.req_op;
                addr_q     <= bus.req_addr;
                operand_q  <= bus.req_operand;
                cmp_q      <= bus.req_cmp;
                retry_q    <= '0;
                rsp_data_q <= '0;
                status_q   <= misaligned ? AtomSt_MISALIGN : AtomSt_OK;
            end
            if (state == ATOM_CALC) begin
                rsp_data_q <= dm_rdata;
                wdata_q    <= alu_new;
                status_q   <= alu_cmp_ok ? AtomSt_OK : AtomSt_CMP_FAIL;
            end
            if (state == ATOM_STORE) begin
                status_q <= cr0_eq ? AtomSt_OK : AtomSt_RETRY;
                if (!cr0_eq && retry_left) retry_q <= retry_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_atomic_seq.sv
// tb_atomic_seq: directed checks of atomic_seq against a one-word memory and scripted cr0_eq
module tb_atomic_seq;
    import atomic_seq_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_rd_en, dm_wr_en, cr0_eq;
    logic [31:0] dm_addr, dm_wdata, rsv_addr;
    logic [31:0] dm_rdata = '0;
    logic [1:0]  rsv_op;
    logic [3:0]  rsv_length;
    logic [31:0] mem_val = '0;
    logic [31:0] last_wdata = '0;
    int rd_cnt = 0, ld_cnt = 0, st_cnt = 0, wr_cnt = 0;
    int rd_base = 0, ld_base = 0, st_base = 0, wr_base = 0;
    int succ_at = 0;
    int checks = 0, failures = 0;
    int lat;

    atomic_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    atomic_seq #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .dm_rd_en(dm_rd_en), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
        .dm_wr_en(dm_wr_en), .dm_wdata(dm_wdata), .rsv_op(rsv_op),
        .rsv_addr(rsv_addr), .rsv_length(rsv_length), .cr0_eq(cr0_eq)
    );

    always #5 clk = ~clk;

    // succ_at selects which store-conditional of the current request succeeds; 0 means none.
    assign cr0_eq = rsv_op == ReserveOp_ST && succ_at != 0 && (st_cnt - st_base + 1 == succ_at);

    always @(posedge clk) begin
        if (dm_rd_en) dm_rdata <= mem_val;
        if (dm_rd_en) rd_cnt <= rd_cnt + 1;
        if (rsv_op == ReserveOp_LD) ld_cnt <= ld_cnt + 1;
        if (rsv_op == ReserveOp_ST) st_cnt <= st_cnt + 1;
        if (dm_wr_en) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= dm_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] o, input logic [31:0] c);
        @(negedge clk);
        rd_base = rd_cnt; ld_base = ld_cnt; st_base = st_cnt; wr_base = wr_cnt;
        bus.req_op = op; bus.req_addr = a; bus.req_operand = o; bus.req_cmp = c;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        while (!bus.rsp_valid && l < 40) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_req_ready_back"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        chk({tag, "_rsp_status"}, 64'(bus.rsp_status), 64'd0);
        chk({tag, "_rd_en"}, 64'(dm_rd_en), 64'd0);
        chk({tag, "_wr_en"}, 64'(dm_wr_en), 64'd0);
        chk({tag, "_dm_addr"}, 64'(dm_addr), 64'd0);
        chk({tag, "_dm_wdata"}, 64'(dm_wdata), 64'd0);
        chk({tag, "_rsv_op"}, 64'(rsv_op), 64'(ReserveOp_NONE));
        chk({tag, "_rsv_length"}, 64'(rsv_length), 64'd4);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0;
        bus.req_operand = '0; bus.req_cmp = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        mem_val = 32'h11; succ_at = 1;
        start(AtomOp_SWAP, 32'h100, 32'h22, 32'h0);
        chk("swap_req_ready_busy", 64'(bus.req_ready), 64'd0);
        chk("swap_dm_addr", 64'(dm_addr), 64'h100);
        chk("swap_rsv_addr", 64'(rsv_addr), 64'h100);
        chk("swap_ld_cycle", 64'(rsv_op), 64'(ReserveOp_LD));
        wait_rsp(lat);
        chk("swap_latency", 64'(lat), 64'd3);
        chk("swap_rsp_data", 64'(bus.rsp_data), 64'h11);
        chk("swap_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
        chk("swap_ld_pulses", 64'(ld_cnt - ld_base), 64'd1);
        chk("swap_rd_pulses", 64'(rd_cnt - rd_base), 64'd1);
        chk("swap_st_pulses", 64'(st_cnt - st_base), 64'd1);
        chk("swap_wdata", 64'(last_wdata), 64'h22);
        finish_rsp("swap");

        mem_val = 32'hFFFF_FFFF; succ_at = 1;
        start(AtomOp_ADD, 32'h200, 32'h2, 32'h0);
        wait_rsp(lat);
        chk("add_latency", 64'(lat), 64'd3);
        chk("add_wdata", 64'(last_wdata), 64'h1);
        chk("add_rsp_data", 64'(bus.rsp_data), 64'hFFFF_FFFF);
        chk("add_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
        finish_rsp("add");

        mem_val = 32'hF0F0_1234; succ_at = 1;
        start(AtomOp_AND, 32'h204, 32'h0FF0_FF00, 32'h0);
        wait_rsp(lat);
        chk("and_wdata", 64'(last_wdata), 64'h00F0_1200);
        chk("and_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
        finish_rsp("and");

        mem_val = 32'd5; succ_at = 1;
        start(AtomOp_CAS, 32'h300, 32'h99, 32'd7);
        wait_rsp(lat);
        chk("casfail_latency", 64'(lat), 64'd2);
        chk("casfail_status", 64'(bus.rsp_status), 64'(AtomSt_CMP_FAIL));
        chk("casfail_rsp_data", 64'(bus.rsp_data), 64'd5);
        chk("casfail_wr_pulses", 64'(wr_cnt - wr_base), 64'd0);
        chk("casfail_st_pulses", 64'(st_cnt - st_base), 64'd0);
        finish_rsp("casfail");

        mem_val = 32'd7; succ_at = 1;
        start(AtomOp_CAS, 32'h304, 32'h99, 32'd7);
        wait_rsp(lat);
        chk("casok_latency", 64'(lat), 64'd3);
        chk("casok_wdata", 64'(last_wdata), 64'h99);
        chk("casok_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
        finish_rsp("casok");

        mem_val = 32'h40; succ_at = 0;
        start(AtomOp_SWAP, 32'h400, 32'h1, 32'h0);
        wait_rsp(lat);
        chk("exhaust_latency", 64'(lat), 64'd15);
        chk("exhaust_status", 64'(bus.rsp_status), 64'(AtomSt_RETRY));
        chk("exhaust_ld_pulses", 64'(ld_cnt - ld_base), 64'd5);
        chk("exhaust_st_pulses", 64'(st_cnt - st_base), 64'd5);
        chk("exhaust_rsp_data", 64'(bus.rsp_data), 64'h40);
        finish_rsp("exhaust");

        mem_val = 32'h41; succ_at = 3;
        start(AtomOp_ADD, 32'h404, 32'h1, 32'h0);
        wait_rsp(lat);
        chk("retry3_latency", 64'(lat), 64'd9);
        chk("retry3_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
        chk("retry3_st_pulses", 64'(st_cnt - st_base), 64'd3);
        chk("retry3_wdata", 64'(last_wdata), 64'h42);
        finish_rsp("retry3");

        mem_val = 32'h77; succ_at = 1;
        start(AtomOp_SWAP, 32'h102, 32'h1, 32'h0);
        chk("misalign_rd_en", 64'(dm_rd_en), 64'd0);
        wait_rsp(lat);
        chk("misalign_latency", 64'(lat), 64'd0);
        chk("misalign_status", 64'(bus.rsp_status), 64'(AtomSt_MISALIGN));
        chk("misalign_rsp_data", 64'(bus.rsp_data), 64'd0);
        @(posedge clk);
        #1 chk("misalign_rd_pulses", 64'(rd_cnt - rd_base), 64'd0);
        chk("misalign_wr_pulses", 64'(wr_cnt - wr_base), 64'd0);
        chk("misalign_rsv_pulses", 64'(ld_cnt - ld_base + st_cnt - st_base), 64'd0);
        finish_rsp("misalign");

        mem_val = 32'hAB; succ_at = 1;
        start(AtomOp_SWAP, 32'h500, 32'hCD, 32'h0);
        wait_rsp(lat);
        chk("bp_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rsp_data", 64'(bus.rsp_data), 64'hAB);
            chk("bp_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        finish_rsp("bp");

        mem_val = 32'h66; succ_at = 1;
        start(AtomOp_ADD, 32'h600, 32'h3, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("rst_in_store", 64'(dm_wr_en), 64'd1);
        rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk) rst_n = 1'b1;
        mem_val = 32'h5; succ_at = 1;
        start(AtomOp_SWAP, 32'h700, 32'h9, 32'h0);
        wait_rsp(lat);
        chk("after_rst_latency", 64'(lat), 64'd3);
        chk("after_rst_rsp_data", 64'(bus.rsp_data), 64'h5);
        chk("after_rst_status", 64'(bus.rsp_status), 64'(AtomSt_OK));
        chk("after_rst_wdata", 64'(last_wdata), 64'h9);
        finish_rsp("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
